// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the UART RX frame checker.
// Used by rx_frame_chk and, with RX_FRAME_ERR_CNT_EN, by rx_sat_cnt.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        PAR   = 3'd2,
        STOP1 = 3'd3,
        STOP2 = 3'd4,
        DONE  = 3'd5
    } rx_state_t;

    localparam int MIN_DATA_LEN = 5;
    localparam int ERR_CNT_W    = 8;

endpackage

// File: rtl/rx_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Only built when RX_FRAME_ERR_CNT_EN is defined.
`ifdef RX_FRAME_ERR_CNT_EN
module rx_sat_cnt
    import rx_frame_pkg::*;
#(
    parameter int W = ERR_CNT_W
) (
    input  logic         clk_RX,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/rx_frame_chk.sv
// UART RX frame checker: tracks data/parity/stop bits from per-bit strobes and reports
// stop, parity and break conditions. Define RX_FRAME_ERR_CNT_EN for saturating error counters.
module rx_frame_chk
    import rx_frame_pkg::*;
#(
    parameter int DATA_W_MAX = 8,
    parameter int LEN_W      = 4
) (
    input  logic             clk_RX,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             bit_vld,
    input  logic             sampled_bit,
    input  logic [LEN_W-1:0] data_len,
    input  logic             par_en,
    input  logic             par_odd,
    input  logic             two_stop,
    output logic             busy,
    output logic             frame_done,
    output logic             Stop_Error,
    output logic             Parity_Error,
    output logic             Break_Det
`ifdef RX_FRAME_ERR_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [ERR_CNT_W-1:0] stop_err_cnt,
    output logic [ERR_CNT_W-1:0] par_err_cnt,
    output logic [ERR_CNT_W-1:0] break_cnt
`endif
);

    rx_state_t        r_state;
    rx_state_t        w_next_state;

    logic [LEN_W-1:0] r_bit_cnt;
    logic [LEN_W-1:0] w_bit_cnt_inc;
    logic             r_par_acc;
    logic             r_any_one;
    logic             r_par_err;
    logic             r_stop_err;

    logic [LEN_W-1:0] r_len;
    logic             r_par_en;
    logic             r_par_odd;
    logic             r_two_stop;

    logic             r_stop_flag;
    logic             r_par_flag;
    logic             r_brk_flag;

    logic             w_data_bit;
    logic             w_par_bit;
    logic             w_stop_bit;
    logic             w_enter_done;

    // Out-of-range lengths fall back to the widest supported frame.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if ((len < LEN_W'(MIN_DATA_LEN)) || (len > LEN_W'(DATA_W_MAX)))
            return LEN_W'(DATA_W_MAX);
        return len;
    endfunction

    assign w_bit_cnt_inc = r_bit_cnt + 1'b1;

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // frame_start overrides everything, including a coincident bit strobe.
    always_comb begin
        w_next_state = r_state;
        w_data_bit   = 1'b0;
        w_par_bit    = 1'b0;
        w_stop_bit   = 1'b0;
        w_enter_done = 1'b0;
        busy         = (r_state != IDLE);
        frame_done   = (r_state == DONE);
        if (frame_start) begin
            w_next_state = DATA;
        end else begin
            case (r_state)
                IDLE: w_next_state = IDLE;
                DATA: begin
                    if (bit_vld) begin
                        w_data_bit = 1'b1;
                        if (w_bit_cnt_inc == r_len)
                            w_next_state = r_par_en ? PAR : STOP1;
                    end
                end
                PAR: begin
                    if (bit_vld) begin
                        w_par_bit    = 1'b1;
                        w_next_state = STOP1;
                    end
                end
                STOP1: begin
                    if (bit_vld) begin
                        w_stop_bit = 1'b1;
                        if (r_two_stop) begin
                            w_next_state = STOP2;
                        end else begin
                            w_next_state = DONE;
                            w_enter_done = 1'b1;
                        end
                    end
                end
                STOP2: begin
                    if (bit_vld) begin
                        w_stop_bit   = 1'b1;
                        w_enter_done = 1'b1;
                        w_next_state = DONE;
                    end
                end
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            r_bit_cnt   <= '0;
            r_par_acc   <= 1'b0;
            r_any_one   <= 1'b0;
            r_par_err   <= 1'b0;
            r_stop_err  <= 1'b0;
            r_len       <= '0;
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_two_stop  <= 1'b0;
            r_stop_flag <= 1'b0;
            r_par_flag  <= 1'b0;
            r_brk_flag  <= 1'b0;
        end else if (frame_start) begin
            r_bit_cnt  <= '0;
            r_par_acc  <= 1'b0;
            r_any_one  <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_len      <= clamp_len(data_len);
            r_par_en   <= par_en;
            r_par_odd  <= par_odd;
            r_two_stop <= two_stop;
        end else begin
            if (w_data_bit) begin
                r_par_acc <= r_par_acc ^ sampled_bit;
                r_any_one <= r_any_one | sampled_bit;
                r_bit_cnt <= w_bit_cnt_inc;
            end
            if (w_par_bit) begin
                r_par_err <= (sampled_bit != (r_par_acc ^ r_par_odd));
                r_any_one <= r_any_one | sampled_bit;
            end
            if (w_stop_bit) begin
                r_stop_err <= r_stop_err | ~sampled_bit;
                r_any_one  <= r_any_one | sampled_bit;
            end
            // Final stop bit is folded in directly so flags are ready in the DONE cycle.
            if (w_enter_done) begin
                r_stop_flag <= r_stop_err | ~sampled_bit;
                r_par_flag  <= r_par_err & r_par_en;
                r_brk_flag  <= ~(r_any_one | sampled_bit);
            end
        end
    end

    assign Stop_Error   = r_stop_flag;
    assign Parity_Error = r_par_flag;
    assign Break_Det    = r_brk_flag;

`ifdef RX_FRAME_ERR_CNT_EN
    rx_sat_cnt #(.W(ERR_CNT_W)) u_stop_cnt (
        .clk_RX (clk_RX),
        .rst    (rst),
        .i_inc  (frame_done & r_stop_flag),
        .i_clr  (cnt_clr),
        .o_cnt  (stop_err_cnt)
    );

    rx_sat_cnt #(.W(ERR_CNT_W)) u_par_cnt (
        .clk_RX (clk_RX),
        .rst    (rst),
        .i_inc  (frame_done & r_par_flag),
        .i_clr  (cnt_clr),
        .o_cnt  (par_err_cnt)
    );

    rx_sat_cnt #(.W(ERR_CNT_W)) u_brk_cnt (
        .clk_RX (clk_RX),
        .rst    (rst),
        .i_inc  (frame_done & r_brk_flag),
        .i_clr  (cnt_clr),
        .o_cnt  (break_cnt)
    );
`endif

endmodule

// File: tb/tb_rx_frame_chk.sv
// Scoreboard bench for rx_frame_chk: directed frames push expected flags and DONE cycle,
// a negedge monitor pops and compares on every frame_done.
module tb_rx_frame_chk;

    logic       clk_RX      = 1'b0;
    logic       rst         = 1'b0;
    logic       frame_start = 1'b0;
    logic       bit_vld     = 1'b0;
    logic       sampled_bit = 1'b0;
    logic [3:0] data_len    = 4'd8;
    logic       par_en      = 1'b0;
    logic       par_odd     = 1'b0;
    logic       two_stop    = 1'b0;
    logic       busy, frame_done, Stop_Error, Parity_Error, Break_Det;
`ifdef RX_FRAME_ERR_CNT_EN
    logic       cnt_clr     = 1'b0;
    logic       clr_in_done = 1'b0;
    logic [7:0] stop_err_cnt, par_err_cnt, break_cnt;
`endif

    rx_frame_chk #(.DATA_W_MAX(8), .LEN_W(4)) dut (
        .clk_RX       (clk_RX),
        .rst          (rst),
        .frame_start  (frame_start),
        .bit_vld      (bit_vld),
        .sampled_bit  (sampled_bit),
        .data_len     (data_len),
        .par_en       (par_en),
        .par_odd      (par_odd),
        .two_stop     (two_stop),
        .busy         (busy),
        .frame_done   (frame_done),
        .Stop_Error   (Stop_Error),
        .Parity_Error (Parity_Error),
        .Break_Det    (Break_Det)
`ifdef RX_FRAME_ERR_CNT_EN
        ,
        .cnt_clr      (cnt_clr),
        .stop_err_cnt (stop_err_cnt),
        .par_err_cnt  (par_err_cnt),
        .break_cnt    (break_cnt)
`endif
    );

    always #5 clk_RX = ~clk_RX;

    int cyc = 0;
    always @(posedge clk_RX) cyc <= cyc + 1;

    typedef struct {
        logic stop;
        logic par;
        logic brk;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_RX) begin : monitor
        exp_t e;
        if (rst && frame_done) begin
            if (q.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("Stop_Error", {31'd0, Stop_Error}, {31'd0, e.stop});
                check("Parity_Error", {31'd0, Parity_Error}, {31'd0, e.par});
                check("Break_Det", {31'd0, Break_Det}, {31'd0, e.brk});
            end
        end
    end

    task automatic tick();
        @(posedge clk_RX);
        #2;
    endtask

    task automatic send_bit(input logic b);
        bit_vld     = 1'b1;
        sampled_bit = b;
        tick();
        bit_vld     = 1'b0;
        tick();
    endtask

    // Config is scrambled right after frame_start to confirm it was latched.
    task automatic run_frame(input logic [3:0] len_cfg, input int nbits, input logic [8:0] data,
                             input logic pe, input logic po, input logic pbit, input logic ts,
                             input logic s1, input logic s2, input logic sim,
                             input logic xs, input logic xp, input logic xb);
        data_len    = len_cfg;
        par_en      = pe;
        par_odd     = po;
        two_stop    = ts;
        frame_start = 1'b1;
        if (sim) begin
            bit_vld     = 1'b1;
            sampled_bit = 1'b1;
        end
        tick();
        frame_start = 1'b0;
        bit_vld     = 1'b0;
        sampled_bit = 1'b0;
        data_len    = 4'd6;
        par_en      = ~pe;
        par_odd     = ~po;
        two_stop    = ~ts;
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (pe) send_bit(pbit);
        if (ts) send_bit(s1);
        q.push_back('{xs, xp, xb, cyc + 1});
        bit_vld     = 1'b1;
        sampled_bit = ts ? s2 : s1;
        tick();
`ifdef RX_FRAME_ERR_CNT_EN
        if (clr_in_done) cnt_clr = 1'b1;
`endif
        bit_vld = 1'b0;
        tick();
`ifdef RX_FRAME_ERR_CNT_EN
        cnt_clr = 1'b0;
`endif
        tick();
    endtask

    initial begin
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_Stop_Error", {31'd0, Stop_Error}, 32'd0);
        check("rst_Parity_Error", {31'd0, Parity_Error}, 32'd0);
        check("rst_Break_Det", {31'd0, Break_Det}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Strobes while idle must not start anything.
        send_bit(1'b1);
        send_bit(1'b0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        //        len   n  data    pe po pb ts s1 s2 sim  xs xp xb
        run_frame(4'd8, 8, 9'h055, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0);  // 8N1 clean
        run_frame(4'd8, 8, 9'h007, 1, 0, 0, 0, 1, 0, 0,   0, 1, 0);  // 8E1 parity error
        run_frame(4'd7, 7, 9'h001, 1, 1, 0, 1, 1, 0, 0,   1, 0, 0);  // 7O2 second stop bad
        run_frame(4'd8, 8, 9'h000, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1);  // break
        run_frame(4'd8, 8, 9'h055, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0);  // clears flags

        // Aborted frame: ones left in the accumulator would corrupt the next parity.
        data_len    = 4'd8;
        par_en      = 1'b0;
        two_stop    = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        run_frame(4'd8, 8, 9'h003, 1, 0, 0, 0, 1, 0, 0,   0, 0, 0);

        run_frame(4'd3, 8, 9'h000, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0);  // len clamp low + coincident bit
        run_frame(4'd12, 8, 9'h080, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0);  // len clamp high
        run_frame(4'd5, 5, 9'h01F, 1, 0, 1, 0, 1, 0, 0,   0, 0, 0);  // 5E1 min length
        run_frame(4'd5, 5, 9'h000, 1, 1, 1, 0, 0, 0, 0,   1, 0, 0);  // only parity bit is 1

        // Async reset while waiting in STOP1.
        check("pre_reset_Stop_Error", {31'd0, Stop_Error}, 32'd1);
        data_len    = 4'd8;
        par_en      = 1'b0;
        two_stop    = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_Stop_Error", {31'd0, Stop_Error}, 32'd0);
        check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        run_frame(4'd6, 6, 9'h02A, 1, 0, 1, 1, 1, 1, 0,   0, 0, 0);  // 6E2 after reset

`ifdef RX_FRAME_ERR_CNT_EN
        for (int i = 0; i < 260; i++)
            run_frame(4'd8, 8, 9'h0FF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("stop_err_cnt_sat", {24'd0, stop_err_cnt}, 32'hFF);
        check("par_err_cnt", {24'd0, par_err_cnt}, 32'h0);
        check("break_cnt", {24'd0, break_cnt}, 32'h0);
        clr_in_done = 1'b1;
        run_frame(4'd8, 8, 9'h0FF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        clr_in_done = 1'b0;
        check("stop_err_cnt_clr", {24'd0, stop_err_cnt}, 32'h0);
        run_frame(4'd8, 8, 9'h000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        check("stop_err_cnt_one", {24'd0, stop_err_cnt}, 32'h1);
        check("break_cnt_one", {24'd0, break_cnt}, 32'h1);
`endif

        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        check("pending_frames", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
